// File: rtl/pdes_q_sched_pkg.sv
// Shared types and default sizing for the PDES event-queue scheduler.
package pdes_q_sched_pkg;

  localparam int DEF_NUM_CORES  = 4;
  localparam int DEF_WIDTH      = 32;
  localparam int DEF_DEPTH      = 5;
  localparam int DEF_STARVE_MAX = 4;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  // Width of a pointer that indexes n requesters; never zero.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pdes_q_sched_if.sv
// Requester, consumer and queue-side signals of the scheduler.
// slave: the scheduler itself; master: the environment around it.
interface pdes_q_sched_if
  import pdes_q_sched_pkg::*;
#(
  parameter int NUM_CORES = DEF_NUM_CORES,
  parameter int WIDTH     = DEF_WIDTH
) ();

  logic [NUM_CORES-1:0]       enq_req;
  logic [NUM_CORES*WIDTH-1:0] enq_data;
  logic [NUM_CORES-1:0]       enq_ack;
  logic                       deq_req;
  logic                       deq_ack;
  logic                       deq_valid;
  logic [WIDTH-1:0]           deq_data;
  logic                       flush;
  logic                       busy;
  logic                       q_enq;
  logic                       q_deq;
  logic [WIDTH-1:0]           q_inp_data;
  logic [WIDTH-1:0]           q_out_data;
  logic                       q_full;
  logic                       q_empty;

  modport slave (
    input  enq_req, enq_data, deq_req, flush, q_out_data, q_full, q_empty,
    output enq_ack, deq_ack, deq_valid, deq_data, busy, q_enq, q_deq, q_inp_data
  );

  modport master (
    output enq_req, enq_data, deq_req, flush, q_out_data, q_full, q_empty,
    input  enq_ack, deq_ack, deq_valid, deq_data, busy, q_enq, q_deq, q_inp_data
  );

endinterface

// File: rtl/pdes_q_sched_rr_arbiter.sv
// Round-robin picker: first set request at or after ptr, wrapping, one-hot out.
module pdes_q_sched_rr_arbiter
  import pdes_q_sched_pkg::*;
#(
  parameter int N = DEF_NUM_CORES,
  localparam int PW = ptr_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  logic          found;
  logic [PW-1:0] idx;

  // Scan requesters starting at ptr; the first hit takes the grant.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(ptr) + i) % N);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pdes_q_sched.sv
// Arbitrates per-core enqueues and a single consumer dequeue onto one
// external priority queue, with anti-starvation for enqueues and a flush mode.
//
//   state | meaning
//   RUN   | normal arbitration between enqueue and dequeue
//   FLUSH | drain the queue with q_deq every cycle, no acks
module pdes_q_sched
  import pdes_q_sched_pkg::*;
#(
  parameter int NUM_CORES  = DEF_NUM_CORES,
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input logic          clk,
  input logic          rst_n,
  pdes_q_sched_if.slave bus
);

  localparam int PW = ptr_w(NUM_CORES);
  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  // A zero-depth queue has no capacity, so it can never accept an event.
  localparam bit HAS_ROOM = (DEPTH > 0);

  state_e               state;
  logic [PW-1:0]        rr_ptr;
  logic [SW-1:0]        starve_cnt;
  logic [NUM_CORES-1:0] rr_grant;
  logic [PW-1:0]        grant_idx;
  logic [WIDTH-1:0]     sel_data;
  logic                 in_run;
  logic                 deq_elig;
  logic                 enq_elig;
  logic                 deq_win;
  logic                 enq_win;

  pdes_q_sched_rr_arbiter #(.N(NUM_CORES)) u_rr_arbiter (
    .req   (bus.enq_req),
    .ptr   (rr_ptr),
    .grant (rr_grant)
  );

  // Eligibility and winner: dequeue first unless enqueues have starved too long.
  always_comb begin
    in_run   = rst_n && (state == RUN);
    deq_elig = in_run && bus.deq_req && !bus.q_empty;
    enq_elig = in_run && HAS_ROOM && (|bus.enq_req) && !bus.q_full;
    enq_win  = enq_elig && (!deq_elig || (starve_cnt == STARVE_LIM));
    deq_win  = deq_elig && !enq_win;
  end

  // Index and event word of the core the arbiter picked.
  always_comb begin
    grant_idx = '0;
    sel_data  = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (rr_grant[i]) begin
        grant_idx = PW'(i);
        sel_data  = bus.enq_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Combinational grants and queue strobes; busy falls as soon as the queue reads empty.
  always_comb begin
    bus.enq_ack    = enq_win ? rr_grant : '0;
    bus.q_enq      = enq_win;
    bus.q_inp_data = enq_win ? sel_data : '0;
    bus.deq_ack    = deq_win;
    bus.busy       = rst_n && (state == FLUSH) && !bus.q_empty;
    bus.q_deq      = deq_win || bus.busy;
  end

  // FSM, round-robin pointer, starvation counter and registered dequeue result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= RUN;
      rr_ptr        <= '0;
      starve_cnt    <= '0;
      bus.deq_valid <= 1'b0;
      bus.deq_data  <= '0;
    end else begin
      case (state)
        RUN:   if (bus.flush)   state <= FLUSH;
        FLUSH: if (bus.q_empty) state <= RUN;
      endcase

      if (enq_win)
        rr_ptr <= (grant_idx == PW'(NUM_CORES - 1)) ? '0 : grant_idx + 1'b1;

      if (!enq_elig || enq_win)
        starve_cnt <= '0;
      else if (deq_win && (starve_cnt != STARVE_LIM))
        starve_cnt <= starve_cnt + 1'b1;

      bus.deq_valid <= deq_win;
      if (deq_win)
        bus.deq_data <= bus.q_out_data;
    end
  end

endmodule

// File: tb/tb_pdes_q_sched.sv
// Bench for pdes_q_sched with a behavioural min-priority queue on the queue side.
module tb_pdes_q_sched;
  import pdes_q_sched_pkg::*;

  localparam int NC  = 4;
  localparam int W   = 32;
  localparam int CAP = 31;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic force_full = 1'b0;
  int n_checks = 0;
  int n_fail = 0;

  logic [W-1:0] pq[$];
  logic [W-1:0] q_out_r = '0;
  logic empty_r = 1'b1;
  logic full_r = 1'b0;

  int           exp_core[$];
  logic [W-1:0] exp_inp[$];
  logic [W-1:0] exp_data[$];
  int           exp_kind[$];

  pdes_q_sched_if #(.NUM_CORES(NC), .WIDTH(W)) bus();

  pdes_q_sched #(.NUM_CORES(NC), .WIDTH(W), .DEPTH(5), .STARVE_MAX(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.q_out_data = q_out_r;
  assign bus.q_empty    = empty_r;
  assign bus.q_full     = full_r | force_full;

  // Queue model: pops the minimum on q_deq, appends on q_enq, registered flags.
  int mi;
  logic [W-1:0] m;
  always @(posedge clk) begin
    if (!rst_n) begin
      pq.delete();
    end else begin
      if (bus.q_deq && pq.size() > 0) begin
        mi = 0;
        for (int i = 1; i < pq.size(); i++) if (pq[i] < pq[mi]) mi = i;
        pq.delete(mi);
      end
      if (bus.q_enq) pq.push_back(bus.q_inp_data);
    end
    m = '1;
    foreach (pq[i]) if (pq[i] < m) m = pq[i];
    q_out_r <= (pq.size() > 0) ? m : '0;
    empty_r <= (pq.size() == 0);
    full_r  <= (pq.size() >= CAP);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic set_data(input int core, input logic [W-1:0] val);
    bus.enq_data[core*W +: W] = val;
  endtask

  task automatic clear_inputs();
    bus.enq_req  = '0;
    bus.enq_data = '0;
    bus.deq_req  = 1'b0;
    bus.flush    = 1'b0;
    force_full   = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    exp_core.delete();
    exp_inp.delete();
    exp_data.delete();
    exp_kind.delete();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic preload(input int n, input logic [W-1:0] base);
    bus.enq_req = 4'b0001;
    for (int i = 0; i < n; i++) begin
      set_data(0, base + W'(i));
      samp();
      n_checks++;
      if (bus.enq_ack !== 4'b0001) begin
        n_fail++;
        $display("FAIL preload_ack[%0d]: got %b want 0001", i, bus.enq_ack);
      end
      step();
    end
    bus.enq_req = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.enq_req = '1;
    bus.enq_data = {NC{32'hA5A5_5A5A}};
    bus.deq_req = 1'b1;
    bus.flush = 1'b1;
    force_full = 1'b0;
    step();
    samp();
    n_checks++;
    if ({bus.enq_ack, bus.deq_ack, bus.q_enq, bus.q_deq, bus.busy, bus.deq_valid} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got ack=%b deq_ack=%b q_enq=%b q_deq=%b busy=%b valid=%b want all 0",
               bus.enq_ack, bus.deq_ack, bus.q_enq, bus.q_deq, bus.busy, bus.deq_valid);
    end
    n_checks++;
    if (bus.q_inp_data !== '0) begin
      n_fail++;
      $display("FAIL reset_q_inp_data: got %h want 0", bus.q_inp_data);
    end
    n_checks++;
    if (bus.deq_data !== '0) begin
      n_fail++;
      $display("FAIL reset_deq_data: got %h want 0", bus.deq_data);
    end
    n_checks++;
    if (dut.state !== RUN || dut.rr_ptr !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got state=%0d rr_ptr=%0d want 0/0", dut.state, dut.rr_ptr);
    end
    step();
    clear_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_two_cores();
    int k;
    logic [W-1:0] v;
    do_reset();
    set_data(0, 32'h10);
    set_data(1, 32'h05);
    bus.enq_req = 4'b0011;
    exp_core.push_back(0); exp_inp.push_back(32'h10);
    exp_core.push_back(1); exp_inp.push_back(32'h05);
    for (int c = 0; c < 2; c++) begin
      samp();
      k = exp_core.pop_front();
      v = exp_inp.pop_front();
      n_checks++;
      if (bus.enq_ack !== NC'(1 << k) || bus.q_inp_data !== v) begin
        n_fail++;
        $display("FAIL two_core_ack[%0d]: got ack=%b data=%h want ack=%b data=%h",
                 c, bus.enq_ack, bus.q_inp_data, NC'(1 << k), v);
      end
      step();
      bus.enq_req[k] = 1'b0;
    end
    bus.deq_req = 1'b1;
    exp_data.push_back(32'h05);
    samp();
    n_checks++;
    if (bus.deq_ack !== 1'b1 || bus.deq_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL two_core_deq_ack: got ack=%b valid=%b want 1/0", bus.deq_ack, bus.deq_valid);
    end
    step();
    bus.deq_req = 1'b0;
    samp();
    v = exp_data.pop_front();
    n_checks++;
    if (bus.deq_valid !== 1'b1 || bus.deq_data !== v) begin
      n_fail++;
      $display("FAIL two_core_deq_data: got valid=%b data=%h want 1/%h", bus.deq_valid, bus.deq_data, v);
    end
    step();
    samp();
    n_checks++;
    if (bus.deq_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL two_core_valid_pulse: got %b want 0", bus.deq_valid);
    end
  endtask

  task automatic test_rr_order();
    int k;
    do_reset();
    for (int i = 0; i < NC; i++) set_data(i, 32'h100 + W'(i));
    bus.enq_req = '1;
    exp_core.push_back(0); exp_core.push_back(1); exp_core.push_back(2);
    exp_core.push_back(3); exp_core.push_back(0);
    for (int c = 0; c < 5; c++) begin
      samp();
      k = exp_core.pop_front();
      n_checks++;
      if (bus.enq_ack !== NC'(1 << k) || bus.q_inp_data !== 32'h100 + W'(k)) begin
        n_fail++;
        $display("FAIL rr_order[%0d]: got ack=%b data=%h want ack=%b data=%h",
                 c, bus.enq_ack, bus.q_inp_data, NC'(1 << k), 32'h100 + W'(k));
      end
      n_checks++;
      if ($countones(bus.enq_ack) > 1) begin
        n_fail++;
        $display("FAIL rr_onehot[%0d]: got %b want at most one bit", c, bus.enq_ack);
      end
      step();
    end
    bus.enq_req = '0;
  endtask

  task automatic test_starve();
    int kind;
    logic [W-1:0] v;
    do_reset();
    preload(20, 32'd100);
    set_data(0, 32'd50);
    bus.enq_req = 4'b0001;
    bus.deq_req = 1'b1;
    for (int g = 0; g < 3; g++) begin
      for (int d = 0; d < 4; d++) exp_kind.push_back(1);
      exp_kind.push_back(0);
    end
    exp_data = '{32'd100, 32'd101, 32'd102, 32'd103, 32'd50, 32'd104,
                 32'd105, 32'd106, 32'd50, 32'd107, 32'd108, 32'd109};
    for (int c = 0; c < 15; c++) begin
      samp();
      kind = exp_kind.pop_front();
      n_checks++;
      if (kind == 1 && (bus.deq_ack !== 1'b1 || bus.enq_ack !== 4'b0000)) begin
        n_fail++;
        $display("FAIL starve_deq[%0d]: got deq_ack=%b enq_ack=%b want 1/0000", c, bus.deq_ack, bus.enq_ack);
      end else if (kind == 0 && (bus.deq_ack !== 1'b0 || bus.enq_ack !== 4'b0001)) begin
        n_fail++;
        $display("FAIL starve_enq[%0d]: got deq_ack=%b enq_ack=%b want 0/0001", c, bus.deq_ack, bus.enq_ack);
      end
      if (bus.deq_valid === 1'b1 && exp_data.size() > 0) begin
        v = exp_data.pop_front();
        n_checks++;
        if (bus.deq_data !== v) begin
          n_fail++;
          $display("FAIL starve_data[%0d]: got %0d want %0d", c, bus.deq_data, v);
        end
      end
      step();
    end
    bus.enq_req = '0;
    bus.deq_req = 1'b0;
    samp();
    n_checks++;
    if (exp_data.size() != 0) begin
      n_fail++;
      $display("FAIL starve_data_left: got %0d results missing want 0", exp_data.size());
    end
  endtask

  task automatic test_full();
    logic [W-1:0] v;
    do_reset();
    preload(2, 32'h200);
    force_full = 1'b1;
    set_data(1, 32'h77);
    bus.enq_req = 4'b0010;
    bus.deq_req = 1'b1;
    exp_data.push_back(32'h200);
    samp();
    n_checks++;
    if (bus.enq_ack !== 4'b0000 || bus.deq_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL full_c1: got enq_ack=%b deq_ack=%b want 0000/1", bus.enq_ack, bus.deq_ack);
    end
    step();
    bus.deq_req = 1'b0;
    samp();
    v = exp_data.pop_front();
    n_checks++;
    if (bus.enq_ack !== 4'b0000 || bus.deq_valid !== 1'b1 || bus.deq_data !== v) begin
      n_fail++;
      $display("FAIL full_c2: got enq_ack=%b valid=%b data=%h want 0000/1/%h",
               bus.enq_ack, bus.deq_valid, bus.deq_data, v);
    end
    step();
    force_full = 1'b0;
    samp();
    n_checks++;
    if (bus.enq_ack !== 4'b0010 || bus.q_inp_data !== 32'h77) begin
      n_fail++;
      $display("FAIL full_release: got ack=%b data=%h want 0010/00000077", bus.enq_ack, bus.q_inp_data);
    end
    step();
    bus.enq_req = '0;
  endtask

  task automatic test_flush();
    logic [W-1:0] v;
    do_reset();
    preload(7, 32'h300);
    bus.flush = 1'b1;
    samp();
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_pulse_busy: got %b want 0", bus.busy);
    end
    step();
    bus.flush = 1'b0;
    bus.deq_req = 1'b1;
    for (int i = 0; i < 7; i++) begin
      samp();
      n_checks++;
      if (bus.busy !== 1'b1 || bus.q_deq !== 1'b1 || bus.deq_ack !== 1'b0 || bus.enq_ack !== '0) begin
        n_fail++;
        $display("FAIL flush_drain[%0d]: got busy=%b q_deq=%b deq_ack=%b enq_ack=%b want 1/1/0/0000",
                 i, bus.busy, bus.q_deq, bus.deq_ack, bus.enq_ack);
      end
      step();
      if (i == 2) bus.flush = 1'b1;
      if (i == 3) bus.flush = 1'b0;
    end
    samp();
    n_checks++;
    if (bus.busy !== 1'b0 || bus.q_deq !== 1'b0 || bus.deq_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_done: got busy=%b q_deq=%b deq_ack=%b want 0/0/0", bus.busy, bus.q_deq, bus.deq_ack);
    end
    step();
    samp();
    n_checks++;
    if (dut.state !== RUN) begin
      n_fail++;
      $display("FAIL flush_run: got state=%0d want %0d", dut.state, RUN);
    end
    step();
    set_data(0, 32'h33);
    bus.enq_req = 4'b0001;
    exp_data.push_back(32'h33);
    samp();
    n_checks++;
    if (bus.enq_ack !== 4'b0001) begin
      n_fail++;
      $display("FAIL flush_resume_enq: got %b want 0001", bus.enq_ack);
    end
    step();
    bus.enq_req = '0;
    samp();
    n_checks++;
    if (bus.deq_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_resume_deq: got %b want 1", bus.deq_ack);
    end
    step();
    bus.deq_req = 1'b0;
    samp();
    v = exp_data.pop_front();
    n_checks++;
    if (bus.deq_valid !== 1'b1 || bus.deq_data !== v) begin
      n_fail++;
      $display("FAIL flush_resume_data: got valid=%b data=%h want 1/%h", bus.deq_valid, bus.deq_data, v);
    end
  endtask

  task automatic test_reset_in_flush();
    do_reset();
    preload(3, 32'h400);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    samp();
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rstflush_busy: got %b want 1", bus.busy);
    end
    step();
    rst_n = 1'b0;
    samp();
    n_checks++;
    if (bus.busy !== 1'b0 || bus.q_deq !== 1'b0) begin
      n_fail++;
      $display("FAIL rstflush_forced: got busy=%b q_deq=%b want 0/0", bus.busy, bus.q_deq);
    end
    step();
    rst_n = 1'b1;
    samp();
    n_checks++;
    if (dut.state !== RUN || bus.busy !== 1'b0 || bus.deq_valid !== 1'b0 || dut.rr_ptr !== '0) begin
      n_fail++;
      $display("FAIL rstflush_after: got state=%0d busy=%b valid=%b rr_ptr=%0d want 0/0/0/0",
               dut.state, bus.busy, bus.deq_valid, dut.rr_ptr);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_inputs();
    test_reset();
    test_two_cores();
    test_rr_order();
    test_starve();
    test_full();
    test_flush();
    test_reset_in_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pdes_q_sched.md
PDES_Q_SCHED -- requirements
Module: pdes_q_sched

Interface
REQ-001 Parameter NUM_CORES, default 4: number of enqueue requesters.
REQ-002 Parameter WIDTH, default 32: event word width, equal to the queue data width.
REQ-003 Parameter DEPTH, default 5: queue depth parameter; capacity is (2^DEPTH)-1 = 31.
REQ-004 Parameter STARVE_MAX, default 4: consecutive dequeue grants allowed while an enqueue is pending.
REQ-005 Port clk, input, 1: single clock; all state updates on posedge.
REQ-006 Port rst_n, input, 1: reset, synchronous, active-low.
REQ-007 Port enq_req, input, NUM_CORES: per-core enqueue request, held until acked.
REQ-008 Port enq_data, input, NUM_CORES*WIDTH: per-core event word; core i occupies bits [i*WIDTH +: WIDTH].
REQ-009 Port enq_ack, output, NUM_CORES: one-hot grant pulse, combinational.
REQ-010 Port deq_req, input, 1: consumer requests the minimum event, held until acked.
REQ-011 Port deq_ack, output, 1: dequeue grant pulse, combinational.
REQ-012 Port deq_valid, output, 1: registered; high for one cycle after deq_ack.
REQ-013 Port deq_data, output, WIDTH: registered head event popped at the deq_ack cycle.
REQ-014 Port flush, input, 1: single-cycle pulse; discards all queued events.
REQ-015 Port busy, output, 1: high while in the FLUSH state.
REQ-016 Queue-side ports: q_enq (out, 1), q_deq (out, 1), q_inp_data (out, WIDTH), q_out_data (in, WIDTH), q_full (in, 1), q_empty (in, 1).

Function
REQ-017 FSM states: RUN and FLUSH. Reset enters RUN. A flush pulse in RUN moves the FSM to FLUSH on the next edge.
REQ-018 FLUSH state: q_deq=1 each cycle while !q_empty; no acks; FSM returns to RUN in the first cycle it observes q_empty.
REQ-019 At most one of q_enq and q_deq is high in any cycle.
REQ-020 A dequeue is eligible only when deq_req=1, q_empty=0 and state=RUN.
REQ-021 An enqueue is eligible only when some enq_req bit=1, q_full=0 and state=RUN.
REQ-022 Dequeue has priority over enqueue.
- Exception: starve_cnt counts consecutive dequeue grants made while an enqueue was eligible.
- When starve_cnt==STARVE_MAX, an eligible enqueue wins and starve_cnt clears.
- Any cycle with no eligible enqueue also clears starve_cnt.
REQ-023 Enqueue winner: round-robin among enq_req bits, starting from rr_ptr.
- On an enqueue grant to core k, rr_ptr becomes (k+1) mod NUM_CORES.
- With no enqueue grant, rr_ptr holds.
REQ-024 Enqueue grant to core k, same cycle: q_enq=1, q_inp_data=enq_data[k], enq_ack[k]=1.
REQ-025 Dequeue grant, same cycle: q_deq=1, deq_ack=1; deq_data<=q_out_data and deq_valid<=1 at that edge.
REQ-026 The flush-pulse cycle itself still arbitrates normally in RUN.
REQ-027 Flush arriving while in FLUSH is ignored.
REQ-028 Requests are never dropped; an unacked request simply waits.
REQ-029 With q_full=1, enqueues stall; dequeues proceed.
REQ-030 With q_empty=1, dequeues stall; enqueues proceed.
REQ-031 starve_cnt width is $clog2(STARVE_MAX+1); it saturates at STARVE_MAX.

Reset
REQ-032 With rst_n=0 at posedge: state=RUN, rr_ptr=0, starve_cnt=0, deq_valid=0, deq_data=0.
REQ-033 While rst_n=0, all combinational outputs are forced to 0: enq_ack, deq_ack, q_enq, q_deq, q_inp_data, busy.
REQ-034 Reset asserted mid-FLUSH aborts the flush; the queue itself is reset separately by the same rst_n.

Structure
REQ-035 Shared package holds the FSM state enum (RUN, FLUSH) and the default NUM_CORES/WIDTH/DEPTH constants.
REQ-036 Sub-module rr_arbiter (NUM_CORES-wide, pointer input, one-hot grant output) holds the round-robin logic.

Verification
REQ-037 Reset, then core0 enq 0x10, core1 enq 0x05 held together -> core0 acked cycle 1, core1 acked cycle 2; a later deq returns deq_data=0x05 with deq_valid one cycle after deq_ack.
REQ-038 All 4 cores request continuously -> acks in order 0,1,2,3,0; never two acks in one cycle.
REQ-039 deq_req and enq_req held with a 20-entry queue -> 4 deq_acks, then 1 enq_ack, then repeat.
REQ-040 q_full=1 with enq_req=1 -> no enq_ack; deq_req=1 is still acked; enq_ack arrives the cycle after q_full drops.
REQ-041 Queue holds 7, flush pulsed -> busy=1 and 7 consecutive q_deq, no acks; busy=0 in the cycle q_empty is seen, with RUN resumed.
REQ-042 rst_n=0 for one cycle during FLUSH -> next cycle state=RUN, busy=0, deq_valid=0, rr_ptr=0.
